// File: rtl/sim_uart_pkg.sv
// Shared types, default constants and helpers for the simulation UART monitor.
package sim_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int         CLK_DIV_115200 = 104;
  localparam logic [7:0] PASS_CHAR_DEF  = 8'h06;
  localparam logic [7:0] FAIL_CHAR_DEF  = 8'h15;

  // Width of a channel index; a single channel still gets one bit.
  function automatic int chan_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sim_uart_monitor_if.sv
// Byte stream from the monitor to its consumer: valid/ready plus channel tag.
interface sim_uart_monitor_if #(parameter int CW = 1) ();
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_chan;
  logic [7:0]    out_data;

  modport master (output out_valid, output out_chan, output out_data, input out_ready);
  modport slave  (input out_valid, input out_chan, input out_data, output out_ready);
endinterface

// File: rtl/sim_uart_rx_chan.sv
// One UART receive lane: 2-FF synchronizer, bit-timing down-counter, 8N1 deframer.
//
//   state | meaning
//   IDLE  | line idle, waiting for a low level
//   START | half-bit wait, then confirm the start bit is still low
//   DATA  | sample 8 data bits LSB first, one per CLK_DIV cycles
//   STOP  | sample the stop bit; after a bad stop, wait for the line to go high
//
// byte_valid / frame_err_pulse are decodes of the stop-sample cycle so the
// holding register in the parent captures the byte on that same edge.
module sim_uart_rx_chan
  import sim_uart_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_115200
) (
  input  logic       clk12,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err_pulse
);

  localparam int BW = $clog2(CLK_DIV);

  logic [1:0]    sync;
  logic          rx_s;
  rx_state_t     state;
  logic [BW-1:0] bitcnt;
  logic [2:0]    bitidx;
  logic [7:0]    shreg;
  logic          brk;
  logic          sample;

  assign rx_s   = sync[1];
  assign sample = (bitcnt == '0);

  assign byte_valid      = (state == STOP) && !brk && sample && rx_s;
  assign frame_err_pulse = (state == STOP) && !brk && sample && !rx_s;
  assign rx_byte         = shreg;

  // Synchronize the asynchronous line; preset high so reset never looks like a start bit.
  always_ff @(posedge clk12) begin
    if (reset) sync <= 2'b11;
    else       sync <= {sync[0], rx};
  end

  // Receive FSM with bit-period down-counter and LSB-first shift register.
  always_ff @(posedge clk12) begin
    if (reset) begin
      state  <= IDLE;
      bitcnt <= '0;
      bitidx <= '0;
      shreg  <= '0;
      brk    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            bitcnt <= BW'(CLK_DIV / 2 - 1);
            state  <= START;
          end
        end
        START: begin
          if (sample) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              bitcnt <= BW'(CLK_DIV - 1);
              bitidx <= '0;
              state  <= DATA;
            end
          end else begin
            bitcnt <= bitcnt - 1'b1;
          end
        end
        DATA: begin
          if (sample) begin
            shreg  <= {rx_s, shreg[7:1]};
            bitcnt <= BW'(CLK_DIV - 1);
            bitidx <= bitidx + 1'b1;
            if (bitidx == 3'd7) state <= STOP;
          end else begin
            bitcnt <= bitcnt - 1'b1;
          end
        end
        STOP: begin
          if (brk) begin
            if (rx_s) begin
              brk   <= 1'b0;
              state <= IDLE;
            end
          end else if (sample) begin
            if (rx_s) state <= IDLE;
            else      brk   <= 1'b1;
          end else begin
            bitcnt <= bitcnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sim_uart_monitor.sv
// Multi-channel UART monitor: per-channel receivers, one-deep holding registers,
// round-robin merge onto a valid/ready stream, pass/fail marker and watchdog flags.
module sim_uart_monitor
  import sim_uart_pkg::*;
#(
  parameter int          NCHAN     = 2,
  parameter int          CLK_DIV   = CLK_DIV_115200,
  parameter logic [7:0]  PASS_CHAR = PASS_CHAR_DEF,
  parameter logic [7:0]  FAIL_CHAR = FAIL_CHAR_DEF,
  parameter logic [31:0] TIMEOUT   = 32'd4_000_000
) (
  input  logic              clk12,
  input  logic              reset,
  input  logic [NCHAN-1:0]  rx,
  sim_uart_monitor_if.master out_if,
  output logic [NCHAN-1:0]  frame_err,
  output logic [NCHAN-1:0]  overrun,
  output logic              sim_done,
  output logic              sim_success,
  output logic              sim_timeout
);

  localparam int CW = chan_w(NCHAN);

  logic [NCHAN-1:0] bv;
  logic [NCHAN-1:0] fe;
  logic [7:0]       bd [NCHAN];

  logic [NCHAN-1:0] hold_full;
  logic [7:0]       hold_data [NCHAN];

  logic             out_valid_q;
  logic [CW-1:0]    out_chan_q;
  logic [7:0]       out_data_q;
  logic [CW-1:0]    rr_ptr;

  logic             hs;
  logic [NCHAN-1:0] pop_mask;
  logic [NCHAN-1:0] avail;
  logic [CW-1:0]    gnt;
  logic             gnt_found;
  int               idx;

  logic             pass_any;
  logic             fail_any;
  logic [31:0]      wd_cnt;
  logic             wd_hit;

  for (genvar g = 0; g < NCHAN; g++) begin : g_chan
    sim_uart_rx_chan #(.CLK_DIV(CLK_DIV)) u_chan (
      .clk12           (clk12),
      .reset           (reset),
      .rx              (rx[g]),
      .byte_valid      (bv[g]),
      .rx_byte         (bd[g]),
      .frame_err_pulse (fe[g])
    );
  end

  assign out_if.out_valid = out_valid_q;
  assign out_if.out_chan  = out_chan_q;
  assign out_if.out_data  = out_data_q;

  // The holding entry of the channel on the output is only released by the handshake.
  assign hs       = out_valid_q && out_if.out_ready;
  assign pop_mask = hs ? (NCHAN'(1) << out_chan_q) : '0;
  assign avail    = hold_full & ~pop_mask;
  assign wd_hit   = (TIMEOUT != 32'd0) && (wd_cnt == TIMEOUT - 32'd1);

  // Round-robin pick: first full holding register at or after rr_ptr.
  always_comb begin
    gnt       = '0;
    gnt_found = 1'b0;
    idx       = 0;
    for (int k = 0; k < NCHAN; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NCHAN) idx = idx - NCHAN;
      if (!gnt_found && avail[idx]) begin
        gnt_found = 1'b1;
        gnt       = CW'(idx);
      end
    end
  end

  // Marker detection on every good byte, whether or not it fits in the holding register.
  always_comb begin
    pass_any = 1'b0;
    fail_any = 1'b0;
    for (int i = 0; i < NCHAN; i++) begin
      if (bv[i] && bd[i] == PASS_CHAR) pass_any = 1'b1;
      if (bv[i] && bd[i] == FAIL_CHAR) fail_any = 1'b1;
    end
  end

  // Holding registers plus sticky overrun/frame-error flags; a full entry keeps its old byte.
  always_ff @(posedge clk12) begin
    if (reset) begin
      hold_full <= '0;
      overrun   <= '0;
      frame_err <= '0;
      for (int i = 0; i < NCHAN; i++) hold_data[i] <= '0;
    end else begin
      for (int i = 0; i < NCHAN; i++) begin
        if (bv[i]) begin
          if (hold_full[i] && !pop_mask[i]) begin
            overrun[i] <= 1'b1;
          end else begin
            hold_full[i] <= 1'b1;
            hold_data[i] <= bd[i];
          end
        end else if (pop_mask[i]) begin
          hold_full[i] <= 1'b0;
        end
        if (fe[i]) frame_err[i] <= 1'b1;
      end
    end
  end

  // Output register: reload when empty or consumed; pointer moves past the consumed channel.
  always_ff @(posedge clk12) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      out_data_q  <= '0;
      rr_ptr      <= '0;
    end else begin
      if ((!out_valid_q || out_if.out_ready) && gnt_found) begin
        out_valid_q <= 1'b1;
        out_chan_q  <= gnt;
        out_data_q  <= hold_data[gnt];
      end else if (out_if.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (hs) rr_ptr <= (out_chan_q == CW'(NCHAN - 1)) ? '0 : out_chan_q + 1'b1;
    end
  end

  // Run-end flags: first event wins, FAIL beats PASS, any marker beats the watchdog.
  always_ff @(posedge clk12) begin
    if (reset) begin
      sim_done    <= 1'b0;
      sim_success <= 1'b0;
      sim_timeout <= 1'b0;
      wd_cnt      <= '0;
    end else if (!sim_done) begin
      wd_cnt <= wd_cnt + 32'd1;
      if (fail_any) begin
        sim_done <= 1'b1;
      end else if (pass_any) begin
        sim_done    <= 1'b1;
        sim_success <= 1'b1;
      end else if (wd_hit) begin
        sim_done    <= 1'b1;
        sim_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sim_uart_monitor.sv
// Directed bench: single-channel vector table plus multi-channel arbitration,
// overrun, marker and watchdog sequences.
module tb_sim_uart_monitor;

  logic       clk12 = 1'b0;
  logic       rst1, rst2, rst3;
  logic [4:0] rx_all;
  logic [0:0] fe1, ov1;
  logic [1:0] fe2, ov2, fe3, ov3;
  logic       done1, succ1, to1, done2, succ2, to2, done3, succ3, to3;
  int         total = 0;
  int         bad   = 0;

  sim_uart_monitor_if #(.CW(1)) if1 ();
  sim_uart_monitor_if #(.CW(1)) if2 ();
  sim_uart_monitor_if #(.CW(1)) if3 ();

  always #5 clk12 = ~clk12;

  sim_uart_monitor #(.NCHAN(1), .CLK_DIV(8), .TIMEOUT(32'd0)) u1 (
    .clk12(clk12), .reset(rst1), .rx(rx_all[0:0]), .out_if(if1),
    .frame_err(fe1), .overrun(ov1), .sim_done(done1), .sim_success(succ1), .sim_timeout(to1));

  sim_uart_monitor #(.NCHAN(2), .CLK_DIV(8), .TIMEOUT(32'd0)) u2 (
    .clk12(clk12), .reset(rst2), .rx(rx_all[2:1]), .out_if(if2),
    .frame_err(fe2), .overrun(ov2), .sim_done(done2), .sim_success(succ2), .sim_timeout(to2));

  sim_uart_monitor #(.NCHAN(2), .CLK_DIV(8), .TIMEOUT(32'd1000)) u3 (
    .clk12(clk12), .reset(rst3), .rx(rx_all[4:3]), .out_if(if3),
    .frame_err(fe3), .overrun(ov3), .sim_done(done3), .sim_success(succ3), .sim_timeout(to3));

  typedef struct {
    logic [7:0] b;
    bit         stop_ok;
    bit         exp_valid;
    logic [7:0] exp_data;
    bit         exp_ferr;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk12);
    #1;
  endtask

  task automatic idle(input int n);
    rx_all = '1;
    repeat (n) step();
  endtask

  // Drives one 8N1 frame (CLK_DIV=8) on rx_all[base +: 2] lanes selected by mask.
  // Returns 1ns after the stop-bit sample edge (start edge + 79).
  task automatic send(input int base, input logic [1:0] mask, input logic [7:0] b0,
                      input logic [7:0] b1, input bit stop_ok);
    logic [9:0] f0, f1;
    f0 = {stop_ok, b0, 1'b0};
    f1 = {stop_ok, b1, 1'b0};
    step();
    for (int t = 0; t < 10; t++) begin
      if (t > 0) repeat (8) step();
      if (mask[0]) rx_all[base]     = f0[t];
      if (mask[1]) rx_all[base + 1] = f1[t];
    end
    repeat (7) step();
  endtask

  initial begin
    int seen;
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'h11, 1'b1, 1'b1, 8'h11, 1'b1};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1};
    vecs[5] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b1};

    rx_all = '1;
    rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
    if1.out_ready = 1'b1; if2.out_ready = 1'b0; if3.out_ready = 1'b1;
    repeat (3) step();

    // watchdog: released at edge 0, counter hits 999 after edge 999, flag after edge 1000
    rst3 = 1'b0;
    repeat (999) step();
    chk("wd_before", {29'd0, done3, succ3, to3}, 32'd0);
    step();
    chk("wd_done", {29'd0, done3, succ3, to3}, {29'd0, 3'b101});

    // reset state of the single-channel instance
    chk("u1_reset", {if1.out_valid, if1.out_chan, if1.out_data, fe1, ov1, done1, succ1, to1}, 32'd0);
    chk("u2_reset", {if2.out_valid, if2.out_chan, if2.out_data, fe2, ov2, done2, succ2, to2}, 32'd0);
    rst1 = 1'b0;
    idle(4);

    // 3-cycle glitch must not start a byte
    rx_all[0] = 1'b0;
    repeat (3) step();
    rx_all[0] = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (if1.out_valid || fe1[0]) seen++;
    end
    chk("glitch_quiet", seen, 0);

    // single-channel vector table
    for (int v = 0; v < 6; v++) begin
      send(0, 2'b01, vecs[v].b, 8'h00, vecs[v].stop_ok);
      chk("lat_early", {31'd0, if1.out_valid}, 32'd0);
      step();
      chk("valid", {31'd0, if1.out_valid}, {31'd0, vecs[v].exp_valid});
      if (vecs[v].exp_valid) begin
        chk("data", {24'd0, if1.out_data}, {24'd0, vecs[v].exp_data});
        chk("chan", {31'd0, if1.out_chan}, 32'd0);
      end
      chk("ferr", {31'd0, fe1}, {31'd0, vecs[v].exp_ferr});
      idle(24);
    end
    chk("u1_no_done", {29'd0, done1, succ1, to1}, 32'd0);
    chk("u1_no_ovr", {31'd0, ov1}, 32'd0);

    // round robin: simultaneous bytes after reset, ch0 first
    rst2 = 1'b0;
    idle(4);
    send(1, 2'b11, 8'h10, 8'h20, 1'b1);
    step();
    chk("rr1_first", {23'd0, if2.out_valid, if2.out_chan, if2.out_data}, {23'd0, 1'b1, 1'b0, 8'h10});
    if2.out_ready = 1'b1;
    step();
    chk("rr1_second", {23'd0, if2.out_valid, if2.out_chan, if2.out_data}, {23'd0, 1'b1, 1'b1, 8'h20});
    step();
    chk("rr1_empty", {31'd0, if2.out_valid}, 32'd0);
    // a lone ch0 byte moves the pointer to ch1
    send(1, 2'b01, 8'h33, 8'h00, 1'b1);
    step();
    chk("rr_single", {23'd0, if2.out_valid, if2.out_chan, if2.out_data}, {23'd0, 1'b1, 1'b0, 8'h33});
    step();
    if2.out_ready = 1'b0;
    idle(8);
    send(1, 2'b11, 8'h44, 8'h55, 1'b1);
    step();
    chk("rr2_first", {23'd0, if2.out_valid, if2.out_chan, if2.out_data}, {23'd0, 1'b1, 1'b1, 8'h55});
    if2.out_ready = 1'b1;
    step();
    chk("rr2_second", {23'd0, if2.out_valid, if2.out_chan, if2.out_data}, {23'd0, 1'b1, 1'b0, 8'h44});
    step();
    chk("rr2_empty", {31'd0, if2.out_valid}, 32'd0);
    if2.out_ready = 1'b0;
    idle(8);

    // overrun: second byte dropped while the first waits
    send(1, 2'b01, 8'h01, 8'h00, 1'b1);
    step();
    chk("ovr_first", {23'd0, if2.out_valid, if2.out_chan, if2.out_data}, {23'd0, 1'b1, 1'b0, 8'h01});
    idle(16);
    send(1, 2'b01, 8'h02, 8'h00, 1'b1);
    step();
    chk("ovr_flag", {30'd0, ov2}, 32'd1);
    chk("ovr_hold", {23'd0, if2.out_valid, if2.out_chan, if2.out_data}, {23'd0, 1'b1, 1'b0, 8'h01});
    idle(8);
    if2.out_ready = 1'b1;
    step();
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (if2.out_valid) seen++;
      step();
    end
    chk("ovr_drained", seen, 0);
    chk("ovr_no_done", {29'd0, done2, succ2, to2}, 32'd0);

    // PASS on ch1, later FAIL ignored
    send(1, 2'b10, 8'h00, 8'h06, 1'b1);
    step();
    chk("pass", {29'd0, done2, succ2, to2}, {29'd0, 3'b110});
    idle(8);
    send(1, 2'b01, 8'h15, 8'h00, 1'b1);
    step();
    chk("pass_sticky", {29'd0, done2, succ2, to2}, {29'd0, 3'b110});
    idle(8);

    // reset clears stickies, then PASS and FAIL in the same cycle
    rst2 = 1'b1;
    repeat (2) step();
    chk("u2_rereset", {if2.out_valid, if2.out_chan, if2.out_data, fe2, ov2, done2, succ2, to2}, 32'd0);
    rst2 = 1'b0;
    idle(4);
    send(1, 2'b11, 8'h06, 8'h15, 1'b1);
    step();
    chk("pass_fail_tie", {29'd0, done2, succ2, to2}, {29'd0, 3'b100});
    idle(20);
    chk("u2_no_ferr", {30'd0, fe2}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
